ibex_multdiv_requester: RTL
===========================

// Module: ibex_multdiv_requester
// PURPOSE
//  Request-side controller for the slow multiplier/divider. Accepts one MUL/DIV op over a
//  valid/ready handshake and drives the multdiv enable/select/operand inputs. Provides the
//  shared 34-bit ALU adder and the two 34-bit intermediate-value registers.
//  Captures the result on multdiv valid and returns it over a valid/ready response port.
// PARAMETERS
//  DataIndTiming  1'b0  1: data_ind_timing_o forced high; 0: taken from req_dit_i
//  PerfCntWidth   32    width of perf counters (only with IBEX_MD_REQ_PERF_EN)
// PORTS
//  clk_i             in   1      clock
//  rst_i             in   1      reset, synchronous, active-high
//  req_valid_i       in   1      request valid
//  req_ready_o       out  1      request accepted when valid&ready
//  req_op_i          in   md_op_e MD_OP_MULL/MULH/DIV/REM
//  req_signed_i      in   2      signed_mode {b,a}
//  req_a_i, req_b_i  in   32     operands
//  req_dit_i         in   1      data-independent timing request
//  rsp_valid_o       out  1      result valid
//  rsp_ready_i       in   1      result consumed when valid&ready
//  rsp_data_o        out  32     result
//  mult_en_o, div_en_o    out 1  dynamic enables to multdiv
//  mult_sel_o, div_sel_o  out 1  static selects to multdiv
//  operator_o        out  md_op_e  latched op
//  signed_mode_o     out  2      latched signed mode
//  op_a_o, op_b_o    out  32     latched operands
//  data_ind_timing_o out  1      latched req_dit_i | DataIndTiming
//  alu_operand_a_i, alu_operand_b_i  in 33  adder inputs from multdiv
//  alu_adder_ext_o   out  34     alu_operand_a_i + alu_operand_b_i (zero-extended)
//  alu_adder_o       out  32     alu_adder_ext_o[32:1]
//  equal_to_zero_o   out  1      alu_adder_o == 0
//  imd_val_d_i[2]    in   34     intermediate next values
//  imd_val_we_i      in   2      per-register write enable
//  imd_val_q_o[2]    out  34     intermediate registers
//  multdiv_ready_id_o out 1      result may retire
//  multdiv_result_i  in   32     multdiv result
//  multdiv_valid_i   in   1      multdiv result valid
// BEHAVIOUR
//  - FSM IDLE -> BUSY -> RESP -> IDLE; reset state IDLE.
//  - IDLE: req_ready_o=1. On req_valid_i, latch op/signed/a/b/dit and go to BUSY.
//  - BUSY:
//    - MULL/MULH: mult_en_o=mult_sel_o=1. DIV/REM: div_en_o=div_sel_o=1.
//    - multdiv_ready_id_o=1.
//    - On multdiv_valid_i, capture multdiv_result_i into rsp_data_o and go to RESP.
//      Enables stay high in the capture cycle so multdiv returns to its IDLE.
//  - RESP: all en/sel=0, rsp_valid_o=1, rsp_data_o stable. On rsp_ready_i go to IDLE.
//    No request is accepted in the same cycle (one bubble).
//  - Latched operator/operands stay stable from accept until RESP exits.
//    Outside BUSY, mult/div en/sel and multdiv_ready_id_o are 0.
//  - Adder: pure combinational, 33b+33b unsigned into 34b; carry out lands in bit 33, no truncation.
//  - imd_val_q_o[k] <= imd_val_d_i[k] when imd_val_we_i[k], in any state.
//  - Latency: MULL with b in {0,1} and dit=0 gives rsp_valid_o 3 cycles after accept.
//    DIV with b=0 and dit=0 gives rsp_valid_o 4 cycles after accept.
//  - Reset values: all outputs 0 except req_ready_o=1. imd regs, rsp_data_o and latched fields are 0.
//  - rst_i mid-op: FSM goes to IDLE next cycle, any pending result is dropped, no rsp_valid_o.
//    The multdiv instance must be reset by the same event.
//  - multdiv_valid_i outside BUSY is ignored.
//  - Assertions: rsp_data_o stable while rsp_valid_o & !rsp_ready_i; mult_en_o & div_en_o never both 1.
// CONFIGURATION
//  IBEX_MD_REQ_PERF_EN
//  - Defined: adds outputs perf_ops_o and perf_busy_cycles_o [PerfCntWidth-1:0].
//    - perf_ops_o increments per completed response.
//    - perf_busy_cycles_o increments each BUSY cycle.
//    - Both saturate at all-ones and reset to 0.
//  - Undefined: the ports and counters do not exist; the rest is identical.
// TESTING
//  - MULL a=7, b=6, unsigned -> rsp_data_o=0x0000002A; imd writes observed.
//  - MULH signed a=b=0x80000000 -> rsp_data_o=0x40000000.
//  - DIV a=5, b=0, dit=0 -> 0xFFFFFFFF, rsp_valid_o 4 cycles after accept.
//    Same with dit=1 -> 0xFFFFFFFF after the full divide.
//  - REM signed a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
//  - Hold rsp_ready_i=0 for 5 cycles with req_valid_i=1:
//    rsp_data_o stable, req_ready_o=0, new op accepted 1 cycle after the response handshake.
//  - Assert rst_i during MD_COMP of a DIV:
//    next cycle IDLE, req_ready_o=1, no rsp_valid_o; a following MULL 3*3 -> 9.

Source files
------------

// File: rtl/ibex_multdiv_requester.sv
// Request-side controller for the slow multiplier/divider.
// Accepts one MUL/DIV operation, drives the multdiv enables, selects and operands,
// provides the shared 34-bit adder and the two intermediate-value registers, and
// returns the captured result over a valid/ready response port.
// Optional feature macro: IBEX_MD_REQ_PERF_EN adds the perf_ops_o and
// perf_busy_cycles_o counters. Without it those ports and counters do not exist.
module ibex_multdiv_requester #(
  parameter bit          DataIndTiming = 1'b0,
  parameter int unsigned PerfCntWidth  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // request port
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_signed_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic        req_dit_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  // multdiv control
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        data_ind_timing_o,
  // shared adder
  input  logic [32:0] alu_operand_a_i,
  input  logic [32:0] alu_operand_b_i,
  output logic [33:0] alu_adder_ext_o,
  output logic [31:0] alu_adder_o,
  output logic        equal_to_zero_o,
  // intermediate-value registers
  input  logic [33:0] imd_val_d_i [2],
  input  logic [1:0]  imd_val_we_i,
  output logic [33:0] imd_val_q_o [2],
  output logic        multdiv_ready_id_o,
  input  logic [31:0] multdiv_result_i,
`ifdef IBEX_MD_REQ_PERF_EN
  output logic [PerfCntWidth-1:0] perf_ops_o,
  output logic [PerfCntWidth-1:0] perf_busy_cycles_o,
`endif
  input  logic        multdiv_valid_i
);

  // Operator encoding shared with the multdiv (MD_OP_MULL/MULH/DIV/REM).
  localparam logic [1:0] MD_OP_MULL = 2'd0;
  localparam logic [1:0] MD_OP_MULH = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;
  localparam logic [1:0] MD_OP_REM  = 2'd3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  if (PerfCntWidth < 1) begin : gen_perf_width_check
    $error("PerfCntWidth must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        dit_q, dit_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [33:0] imd_q [2];
  logic [33:0] imd_d [2];

  logic st_idle, st_busy, st_resp;
  logic is_div_op;

  assign st_idle   = (state_q == StIdle);
  assign st_busy   = (state_q == StBusy);
  assign st_resp   = (state_q == StResp);
  // DIV and REM share the upper encoding bit; MULL and MULH have it clear.
  assign is_div_op = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

  // Next-state, operand latching on accept and result capture on multdiv valid.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sgn_d      = sgn_q;
    a_d        = a_q;
    b_d        = b_q;
    dit_d      = dit_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          sgn_d   = req_signed_i;
          a_d     = req_a_i;
          b_d     = req_b_i;
          dit_d   = req_dit_i | DataIndTiming;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Enables stay high in this cycle so the multdiv sees its own completion.
        if (multdiv_valid_i) begin
          rsp_data_d = multdiv_result_i;
          state_d    = StResp;
        end
      end
      StResp: begin
        // Return to IDLE only; a new request waits one cycle.
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and latched-field registers; reset drops any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= MD_OP_MULL;
      sgn_q      <= 2'b00;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      dit_q      <= 1'b0;
      rsp_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sgn_q      <= sgn_d;
      a_q        <= a_d;
      b_q        <= b_d;
      dit_q      <= dit_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Intermediate-value next state: per-register write enable, independent of FSM state.
  always_comb begin
    imd_d[0] = imd_q[0];
    imd_d[1] = imd_q[1];
    if (imd_val_we_i[0]) imd_d[0] = imd_val_d_i[0];
    if (imd_val_we_i[1]) imd_d[1] = imd_val_d_i[1];
  end

  // Intermediate-value registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imd_q[0] <= 34'h0;
      imd_q[1] <= 34'h0;
    end else begin
      imd_q[0] <= imd_d[0];
      imd_q[1] <= imd_d[1];
    end
  end

  assign req_ready_o        = st_idle;
  assign rsp_valid_o        = st_resp;
  assign rsp_data_o         = rsp_data_q;
  assign mult_en_o          = st_busy & ~is_div_op;
  assign mult_sel_o         = st_busy & ~is_div_op;
  assign div_en_o           = st_busy & is_div_op;
  assign div_sel_o          = st_busy & is_div_op;
  assign multdiv_ready_id_o = st_busy;
  assign operator_o         = op_q;
  assign signed_mode_o      = sgn_q;
  assign op_a_o             = a_q;
  assign op_b_o             = b_q;
  assign data_ind_timing_o  = dit_q;
  assign imd_val_q_o[0]     = imd_q[0];
  assign imd_val_q_o[1]     = imd_q[1];

  // Shared adder: both operands zero-extended so the carry lands in bit 33.
  assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
  assign alu_adder_o     = alu_adder_ext_o[32:1];
  assign equal_to_zero_o = (alu_adder_o == 32'h0);

`ifdef IBEX_MD_REQ_PERF_EN
  logic [PerfCntWidth-1:0] perf_ops_q, perf_ops_d;
  logic [PerfCntWidth-1:0] perf_busy_q, perf_busy_d;

  // Saturating counters: completed responses and cycles spent in BUSY.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if (st_resp && rsp_ready_i && (perf_ops_q != {PerfCntWidth{1'b1}})) begin
      perf_ops_d = perf_ops_q + PerfCntWidth'(1);
    end
    if (st_busy && (perf_busy_q != {PerfCntWidth{1'b1}})) begin
      perf_busy_d = perf_busy_q + PerfCntWidth'(1);
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops_o         = perf_ops_q;
  assign perf_busy_cycles_o = perf_busy_q;
`endif

  a_rsp_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_data_o));

  a_en_onehot: assert property (@(posedge clk_i) !(mult_en_o && div_en_o));

endmodule
